// File: rtl/xadc_joy_sequencer.sv
// Joystick scanner: on each tick, reads four XADC channels over DRP and turns the
// top nibble of each conversion into up/down/left/right flags for two players.
module xadc_joy_sequencer #(
    parameter logic [3:0] LOW_TH  = 4'd0,
    parameter logic [3:0] HIGH_TH = 4'd12,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic [6:0]  daddr,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic        scan_done,
    output logic        timeout_err
);

    // state | meaning
    // IDLE  | waiting for a scan request (tick)
    // ISSUE | den pulse, daddr presents the current slot
    // WAIT  | waiting for drdy, bounded by TIMEOUT cycles
    // DONE  | directions just refreshed, scan_done pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] slot;
    logic [7:0] count;
    logic [7:0] shadow;
    logic [1:0] flags;
    logic [7:0] shadow_next;
    logic       expired;
    logic       advance;
    logic       unused_bits;

    function automatic logic [6:0] slot_addr(input logic [1:0] s);
        case (s)
            2'd0:    slot_addr = 7'h16;
            2'd1:    slot_addr = 7'h1E;
            2'd2:    slot_addr = 7'h17;
            default: slot_addr = 7'h1F;
        endcase
    endfunction

    // Vertical {up,down} and horizontal {left,right} share the {low,high} ordering,
    // so every slot maps onto one 2-bit field of {p1_dir, p2_dir}.
    always_comb begin
        flags = 2'b00;
        if (drdy) begin
            flags = {do_in[15:12] <= LOW_TH, do_in[15:12] >= HIGH_TH};
        end
        shadow_next = shadow;
        case (slot)
            2'd0:    shadow_next[7:6] = flags;
            2'd1:    shadow_next[5:4] = flags;
            2'd2:    shadow_next[3:2] = flags;
            default: shadow_next[1:0] = flags;
        endcase
    end

    assign expired     = (count == TIMEOUT - 8'd1);
    assign advance     = drdy || expired;
    assign unused_bits = ^do_in[11:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot        <= 2'd0;
            count       <= 8'd0;
            den         <= 1'b0;
            daddr       <= 7'h16;
            p1_dir      <= 4'd0;
            p2_dir      <= 4'd0;
            shadow      <= 8'd0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            den         <= 1'b0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= ISSUE;
                        slot  <= 2'd0;
                        den   <= 1'b1;
                        daddr <= slot_addr(2'd0);
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    count <= 8'd0;
                end
                WAIT: begin
                    if (advance) begin
                        // A timed-out slot takes the neutral flags from shadow_next.
                        shadow      <= shadow_next;
                        timeout_err <= ~drdy;
                        if (slot == 2'd3) begin
                            state     <= DONE;
                            scan_done <= 1'b1;
                            p1_dir    <= shadow_next[7:4];
                            p2_dir    <= shadow_next[3:0];
                        end else begin
                            state <= ISSUE;
                            slot  <= slot + 2'd1;
                            den   <= 1'b1;
                            daddr <= slot_addr(slot + 2'd1);
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_joy_sequencer.sv
// Bench for xadc_joy_sequencer: a DRP responder drives each scan, and a slot-level
// timing/threshold model predicts addresses, timeouts, scan_done timing and directions.
module tb_xadc_joy_sequencer;

    localparam int         TO    = 4;
    localparam logic [3:0] LO_TH = 4'd0;
    localparam logic [3:0] HI_TH = 4'd12;
    localparam int         SCAN_BUDGET = 4 * (1 + TO) + 1 + 8;
    localparam logic [6:0] ADDR_TBL [4] = '{7'h16, 7'h1E, 7'h17, 7'h1F};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = 16'h0000;
    logic        den;
    logic [6:0]  daddr;
    logic [3:0]  p1_dir;
    logic [3:0]  p2_dir;
    logic        scan_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Per-scan stimulus: dly[s] = WAIT cycle index in which drdy is raised (>= TO means never)
    int         dly [4];
    logic [3:0] nib [4];

    int         obs_den_cyc [$];
    logic [6:0] obs_addr [$];
    int         obs_sd_cyc [$];
    int         obs_te_cyc [$];
    int         obs_hold_bad;
    int         obs_dir_bad;

    int         exp_den_cyc [$];
    int         exp_te_cyc [$];
    logic [7:0] exp_dirs;
    int         exp_done;

    xadc_joy_sequencer #(
        .LOW_TH (LO_TH),
        .HIGH_TH(HI_TH),
        .TIMEOUT(8'(TO))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .drdy       (drdy),
        .do_in      (do_in),
        .den        (den),
        .daddr      (daddr),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .scan_done  (scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] classify(input logic [3:0] n);
        return {n <= LO_TH, n >= HI_TH};
    endfunction

    // Cycle numbers are counted from the edge that sampled tick (cycle 0 = ISSUE of slot 0).
    function automatic void build_model();
        int t;
        t = 0;
        exp_den_cyc.delete();
        exp_te_cyc.delete();
        exp_dirs = 8'h00;
        for (int s = 0; s < 4; s++) begin
            exp_den_cyc.push_back(t);
            if (dly[s] < TO) begin
                t = t + 1 + dly[s] + 1;
                exp_dirs[7 - 2 * s -: 2] = classify(nib[s]);
            end else begin
                t = t + 1 + TO;
                exp_te_cyc.push_back(t);
            end
        end
        exp_done = t;
    endfunction

    // Issues one tick, answers DRP reads per dly/nib, and records what the DUT did.
    task automatic run_scan(input int retick_slot, input int abort_slot, output bit aborted);
        int         s;
        int         w;
        bit         waiting;
        logic [7:0] dirs_prev;
        logic [6:0] cur_addr;
        obs_den_cyc.delete();
        obs_addr.delete();
        obs_sd_cyc.delete();
        obs_te_cyc.delete();
        obs_hold_bad = 0;
        obs_dir_bad  = 0;
        aborted  = 1'b0;
        s        = -1;
        w        = 0;
        waiting  = 1'b0;
        cur_addr = 7'h00;
        dirs_prev = {p1_dir, p2_dir};
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        for (int cyc = 0; cyc < SCAN_BUDGET; cyc++) begin
            if ({p1_dir, p2_dir} !== dirs_prev && !scan_done) obs_dir_bad++;
            dirs_prev = {p1_dir, p2_dir};
            if (scan_done) begin
                obs_sd_cyc.push_back(cyc);
                waiting = 1'b0;
            end
            if (timeout_err) obs_te_cyc.push_back(cyc);
            drdy  = 1'b0;
            tick  = 1'b0;
            do_in = 16'($urandom);
            if (den) begin
                s++;
                obs_den_cyc.push_back(cyc);
                obs_addr.push_back(daddr);
                cur_addr = daddr;
                waiting  = 1'b1;
                w        = -1;
            end else if (waiting) begin
                w++;
                if (daddr !== cur_addr) obs_hold_bad++;
                if (s == abort_slot && w == 0) begin
                    aborted = 1'b1;
                    break;
                end
                if (s == retick_slot && w == 0) tick = 1'b1;
                if (s >= 0 && s < 4 && w == dly[s]) begin
                    drdy    = 1'b1;
                    do_in   = {nib[s], 12'($urandom)};
                    waiting = 1'b0;
                end
            end
            if (obs_sd_cyc.size() > 0 && cyc >= obs_sd_cyc[0] + 4) break;
            @(posedge clk);
            @(negedge clk);
        end
        drdy = 1'b0;
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (den !== 1'b0) begin errors++; $display("FAIL reset_den got %b want 0", den); end
        checks++; if (daddr !== 7'h16) begin errors++; $display("FAIL reset_daddr got %h want 16", daddr); end
        checks++; if (p1_dir !== 4'b0000) begin errors++; $display("FAIL reset_p1 got %b want 0000", p1_dir); end
        checks++; if (p2_dir !== 4'b0000) begin errors++; $display("FAIL reset_p2 got %b want 0000", p2_dir); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got %b want 0", scan_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_scan();
        bit ab;
        int sd;
        dly = '{0, 0, 0, 0};
        nib = '{4'd0, 4'd12, 4'd15, 4'd5};
        run_scan(-1, -1, ab);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (obs_addr.size() <= s || obs_addr[s] !== ADDR_TBL[s]) begin
                errors++;
                $display("FAIL basic_daddr slot %0d got %h want %h", s, (obs_addr.size() > s) ? obs_addr[s] : 7'h00, ADDR_TBL[s]);
            end
        end
        sd = (obs_sd_cyc.size() == 1) ? obs_sd_cyc[0] : -1;
        checks++; if (sd !== 8) begin errors++; $display("FAIL basic_scan_done_cycle got %0d want 8 (count %0d)", sd, obs_sd_cyc.size()); end
        checks++; if (obs_te_cyc.size() !== 0) begin errors++; $display("FAIL basic_timeouts got %0d want 0", obs_te_cyc.size()); end
        checks++; if (p1_dir !== 4'b1001) begin errors++; $display("FAIL basic_p1 got %b want 1001", p1_dir); end
        checks++; if (p2_dir !== 4'b0100) begin errors++; $display("FAIL basic_p2 got %b want 0100", p2_dir); end
        checks++; if (obs_dir_bad !== 0) begin errors++; $display("FAIL basic_dir_hold got %0d stray changes want 0", obs_dir_bad); end
    endtask

    task automatic test_timeout();
        bit ab;
        int sd;
        int te;
        dly = '{0, TO + 5, 0, 0};
        nib = '{4'($urandom_range(0, 15)), 4'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        build_model();
        run_scan(-1, -1, ab);
        te = (obs_te_cyc.size() == 1) ? obs_te_cyc[0] : -1;
        checks++; if (te !== 7) begin errors++; $display("FAIL timeout_pulse_cycle got %0d want 7 (count %0d)", te, obs_te_cyc.size()); end
        checks++; if (p1_dir[1:0] !== 2'b00) begin errors++; $display("FAIL timeout_p1_lr got %b want 00", p1_dir[1:0]); end
        checks++; if ({p1_dir, p2_dir} !== exp_dirs) begin errors++; $display("FAIL timeout_dirs got %h want %h", {p1_dir, p2_dir}, exp_dirs); end
        sd = (obs_sd_cyc.size() == 1) ? obs_sd_cyc[0] : -1;
        checks++; if (sd !== exp_done) begin errors++; $display("FAIL timeout_scan_done got %0d want %0d (count %0d)", sd, exp_done, obs_sd_cyc.size()); end
    endtask

    task automatic test_retick();
        bit ab;
        for (int s = 0; s < 4; s++) begin
            dly[s] = $urandom_range(0, 2);
            nib[s] = 4'($urandom_range(0, 15));
        end
        build_model();
        run_scan(2, -1, ab);
        checks++; if (obs_sd_cyc.size() !== 1) begin errors++; $display("FAIL retick_scan_done_count got %0d want 1", obs_sd_cyc.size()); end
        checks++; if (obs_den_cyc.size() !== 4) begin errors++; $display("FAIL retick_den_count got %0d want 4", obs_den_cyc.size()); end
        checks++; if ({p1_dir, p2_dir} !== exp_dirs) begin errors++; $display("FAIL retick_dirs got %h want %h", {p1_dir, p2_dir}, exp_dirs); end
        checks++; if (obs_dir_bad !== 0) begin errors++; $display("FAIL retick_dir_hold got %0d stray changes want 0", obs_dir_bad); end
    endtask

    task automatic test_reset_mid_scan();
        bit ab;
        int den_seen;
        int sd_seen;
        dly = '{0, 0, 0, 0};
        nib = '{4'd15, 4'd0, 4'd0, 4'd15};
        run_scan(-1, 2, ab);
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL midreset_reached_slot2 got %b want 1", ab); end
        reset = 1'b1;
        #1;
        checks++; if ({den, scan_done, timeout_err} !== 3'b000) begin errors++; $display("FAIL midreset_pulses got %b want 000", {den, scan_done, timeout_err}); end
        checks++; if ({p1_dir, p2_dir} !== 8'h00) begin errors++; $display("FAIL midreset_dirs got %h want 00", {p1_dir, p2_dir}); end
        checks++; if (daddr !== 7'h16) begin errors++; $display("FAIL midreset_daddr got %h want 16", daddr); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        den_seen = 0;
        sd_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            drdy  = 1'($urandom);
            do_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (den) den_seen++;
            if (scan_done) sd_seen++;
        end
        drdy = 1'b0;
        checks++; if (sd_seen !== 0) begin errors++; $display("FAIL midreset_no_scan_done got %0d want 0", sd_seen); end
        checks++; if (den_seen !== 0) begin errors++; $display("FAIL midreset_no_den got %0d want 0", den_seen); end
        for (int s = 0; s < 4; s++) begin
            dly[s] = $urandom_range(0, 3);
            nib[s] = 4'($urandom_range(0, 15));
        end
        build_model();
        run_scan(-1, -1, ab);
        checks++; if (obs_addr.size() !== 4 || obs_addr[0] !== 7'h16) begin errors++; $display("FAIL midreset_restart_slot0 got %0d reads, first %h want 4 reads from 16", obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 7'h00); end
        checks++; if ({p1_dir, p2_dir} !== exp_dirs) begin errors++; $display("FAIL midreset_restart_dirs got %h want %h", {p1_dir, p2_dir}, exp_dirs); end
    endtask

    task automatic test_coincident();
        bit ab;
        dly = '{TO - 1, TO - 1, TO - 1, TO - 1};
        nib = '{4'd13, 4'd13, 4'd13, 4'd13};
        build_model();
        run_scan(-1, -1, ab);
        checks++; if (obs_te_cyc.size() !== 0) begin errors++; $display("FAIL coincident_timeouts got %0d want 0", obs_te_cyc.size()); end
        checks++; if (p1_dir !== 4'b0101) begin errors++; $display("FAIL coincident_p1 got %b want 0101", p1_dir); end
        checks++; if (p2_dir !== 4'b0101) begin errors++; $display("FAIL coincident_p2 got %b want 0101", p2_dir); end
    endtask

    task automatic test_spurious_drdy();
        int den_seen;
        int sd_seen;
        den_seen = 0;
        sd_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            drdy  = 1'b1;
            do_in = {4'd0, 12'($urandom)};
            @(posedge clk);
            @(negedge clk);
            if (den) den_seen++;
            if (scan_done) sd_seen++;
        end
        drdy = 1'b0;
        checks++; if ({p1_dir, p2_dir} !== exp_dirs) begin errors++; $display("FAIL spurious_dirs got %h want %h", {p1_dir, p2_dir}, exp_dirs); end
        checks++; if (den_seen !== 0) begin errors++; $display("FAIL spurious_den got %0d want 0", den_seen); end
        checks++; if (sd_seen !== 0) begin errors++; $display("FAIL spurious_scan_done got %0d want 0", sd_seen); end
    endtask

    task automatic test_max_duration();
        bit ab;
        int sd;
        dly = '{TO + 1, TO + 1, TO + 1, TO + 1};
        nib = '{4'd0, 4'd15, 4'd0, 4'd15};
        build_model();
        run_scan(-1, -1, ab);
        sd = (obs_sd_cyc.size() == 1) ? obs_sd_cyc[0] : -1;
        checks++; if (sd + 1 !== 4 * (1 + TO) + 1) begin errors++; $display("FAIL max_duration got %0d want %0d", sd + 1, 4 * (1 + TO) + 1); end
        checks++; if (obs_te_cyc.size() !== 4) begin errors++; $display("FAIL max_timeout_count got %0d want 4", obs_te_cyc.size()); end
        checks++; if ({p1_dir, p2_dir} !== 8'h00) begin errors++; $display("FAIL max_dirs got %h want 00", {p1_dir, p2_dir}); end
    endtask

    task automatic test_random_scans();
        bit ab;
        int sd;
        for (int it = 0; it < 20; it++) begin
            for (int s = 0; s < 4; s++) begin
                dly[s] = $urandom_range(0, TO + 1);
                nib[s] = 4'($urandom_range(0, 15));
            end
            build_model();
            run_scan(-1, -1, ab);
            checks++; if ({p1_dir, p2_dir} !== exp_dirs) begin errors++; $display("FAIL rand%0d_dirs got %h want %h", it, {p1_dir, p2_dir}, exp_dirs); end
            sd = (obs_sd_cyc.size() == 1) ? obs_sd_cyc[0] : -1;
            checks++; if (sd !== exp_done) begin errors++; $display("FAIL rand%0d_scan_done got %0d want %0d", it, sd, exp_done); end
            checks++;
            if (obs_te_cyc.size() !== exp_te_cyc.size()) begin
                errors++; $display("FAIL rand%0d_timeout_count got %0d want %0d", it, obs_te_cyc.size(), exp_te_cyc.size());
            end else begin
                for (int k = 0; k < exp_te_cyc.size(); k++) begin
                    checks++; if (obs_te_cyc[k] !== exp_te_cyc[k]) begin errors++; $display("FAIL rand%0d_timeout_cycle got %0d want %0d", it, obs_te_cyc[k], exp_te_cyc[k]); end
                end
            end
            checks++;
            if (obs_den_cyc.size() !== 4) begin
                errors++; $display("FAIL rand%0d_den_count got %0d want 4", it, obs_den_cyc.size());
            end else begin
                for (int s = 0; s < 4; s++) begin
                    checks++; if (obs_den_cyc[s] !== exp_den_cyc[s] || obs_addr[s] !== ADDR_TBL[s]) begin errors++; $display("FAIL rand%0d_read%0d got cyc %0d addr %h want cyc %0d addr %h", it, s, obs_den_cyc[s], obs_addr[s], exp_den_cyc[s], ADDR_TBL[s]); end
                end
            end
            checks++; if (obs_hold_bad !== 0 || obs_dir_bad !== 0) begin errors++; $display("FAIL rand%0d_hold got daddr %0d dirs %0d stray changes want 0", it, obs_hold_bad, obs_dir_bad); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_timeout();
        test_retick();
        test_reset_mid_scan();
        test_coincident();
        test_spurious_drdy();
        test_max_duration();
        test_random_scans();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/xadc_joy_sequencer.md
XADC_JOY_SEQUENCER -- requirements
Module: xadc_joy_sequencer

Interface
REQ-001 SHALL have parameter LOW_TH, default 4'd0: conversion upper nibble <= LOW_TH means "low deflection".
REQ-002 SHALL have parameter HIGH_TH, default 4'd12: conversion upper nibble >= HIGH_TH means "high deflection"; LOW_TH < HIGH_TH is required.
REQ-003 SHALL have parameter TIMEOUT, default 8'd255, range 1..255: maximum WAIT cycles per channel.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port tick  in  1  scan request strobe (e.g. one-clk pulse per frame).
REQ-007 SHALL have port drdy  in  1  XADC DRP data-ready.
REQ-008 SHALL have port do_in  in  16  XADC DRP read data; only bits [15:12] are used.
REQ-009 SHALL have port den  out  1  DRP enable, one-cycle pulse per read.
REQ-010 SHALL have port daddr  out  7  DRP address.
REQ-011 SHALL have port p1_dir  out  4  player 1 {up,down,left,right}.
REQ-012 SHALL have port p2_dir  out  4  player 2 {up,down,left,right}.
REQ-013 SHALL have port scan_done  out  1  one-cycle pulse when p1_dir/p2_dir are refreshed.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse when a channel read times out.

Function
REQ-015 SHALL scan four slots in fixed order: slot0 daddr 7'h16 (P1 vertical), slot1 7'h1E (P1 horizontal), slot2 7'h17 (P2 vertical), slot3 7'h1F (P2 horizontal).
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: tick high -> ISSUE with slot=0; otherwise remain in IDLE.
REQ-018 ISSUE (exactly 1 cycle): den=1, daddr=slot address -> WAIT, WAIT counter cleared to 0.
REQ-019 WAIT: daddr held; den=0; counter increments each cycle; drdy=1 -> capture do_in[15:12] and decode slot into shadow flags.
REQ-020 WAIT: if drdy=0 and counter==TIMEOUT-1, SHALL pulse timeout_err, set that slot's two flags to 0 (neutral), and advance as if drdy.
REQ-021 drdy and timeout in the same cycle: drdy wins, no timeout_err.
REQ-022 Advance from WAIT: slot<3 -> slot+1, ISSUE; slot==3 -> DONE.
REQ-023 Vertical slots: up = nibble<=LOW_TH, down = nibble>=HIGH_TH; horizontal slots: left = nibble<=LOW_TH, right = nibble>=HIGH_TH; a mid-range nibble gives both flags 0.
REQ-024 p1_dir/p2_dir SHALL update together, all 8 bits at once, on the edge entering DONE (slot3 result included); they SHALL hold all other times.
REQ-025 DONE (exactly 1 cycle): scan_done=1 -> IDLE.
REQ-026 tick while not in IDLE SHALL be ignored (not queued); drdy outside WAIT SHALL be ignored.
REQ-027 Minimum latency: with drdy in each slot's first WAIT cycle, scan_done is high 9 cycles after the edge that sampled tick.
REQ-028 Maximum scan duration SHALL be 4*(1+TIMEOUT)+1 cycles.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, slot=0, counter=0, den=0, daddr=7'h16, p1_dir=p2_dir=0, shadow flags=0, scan_done=0, timeout_err=0.
REQ-030 Reset mid-scan SHALL abort with no scan_done; the first scan after release requires a new tick.

Verification
REQ-031 Single tick, drdy 1 cycle after each den, nibbles 0,12,15,5 -> daddr seq 16,1E,17,1F; scan_done 9 cycles after tick; p1_dir=4'b1001, p2_dir=4'b0100.
REQ-032 Slot1 drdy never asserted, TIMEOUT=4 -> timeout_err pulse after 4 WAIT cycles, P1 left/right=0, scan completes, scan_done once.
REQ-033 tick pulsed again during WAIT of slot2 -> exactly one scan_done and one refresh; no restart.
REQ-034 reset asserted during slot2 WAIT -> outputs 0 asynchronously, no scan_done; next tick runs a full scan from slot0.
REQ-035 drdy coincident with the TIMEOUT-1 counter value, nibble 13 -> no timeout_err, down/right flag set per slot.
REQ-036 Spurious drdy in IDLE with nibble 0 -> p1_dir/p2_dir unchanged, den stays 0.
